sseg_scan_decoder: RTL

- Receive end of the multiplexed seven-segment display interface.
- Watches the scanned, active-low anode and segment lines that the display driver presents.
- Inverts the segment code table back to hex nibbles and rebuilds the N-digit value shown on the display.
- Used for on-chip self-check of the display path and for loopback benches.

---
 rtl/sseg_pkg.sv | 52 +++++
 rtl/sseg_to_hex.sv | 24 ++
 rtl/sseg_scan_decoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared seven-segment code table (active-low, bit 6 = g ... bit 0 = a) and scan FSM states.
// The display encoder and sseg_to_hex both draw on hex_to_sseg so the two tables cannot drift apart.
package sseg_pkg;

  localparam logic [6:0] SSEG_0     = 7'b1000000;
  localparam logic [6:0] SSEG_1     = 7'b1111001;
  localparam logic [6:0] SSEG_2     = 7'b0100100;
  localparam logic [6:0] SSEG_3     = 7'b0110000;
  localparam logic [6:0] SSEG_4     = 7'b0011001;
  localparam logic [6:0] SSEG_5     = 7'b0010010;
  localparam logic [6:0] SSEG_6     = 7'b0000010;
  localparam logic [6:0] SSEG_7     = 7'b1111000;
  localparam logic [6:0] SSEG_8     = 7'b0000000;
  localparam logic [6:0] SSEG_9     = 7'b0010000;
  localparam logic [6:0] SSEG_A     = 7'b0001000;
  localparam logic [6:0] SSEG_B     = 7'b0000011;
  localparam logic [6:0] SSEG_C     = 7'b1000110;
  localparam logic [6:0] SSEG_D     = 7'b0100001;
  localparam logic [6:0] SSEG_E     = 7'b0000110;
  localparam logic [6:0] SSEG_F     = 7'b0001110;
  localparam logic [6:0] SSEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_e;

  function automatic logic [6:0] hex_to_sseg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = SSEG_0;
      4'h1:    seg = SSEG_1;
      4'h2:    seg = SSEG_2;
      4'h3:    seg = SSEG_3;
      4'h4:    seg = SSEG_4;
      4'h5:    seg = SSEG_5;
      4'h6:    seg = SSEG_6;
      4'h7:    seg = SSEG_7;
      4'h8:    seg = SSEG_8;
      4'h9:    seg = SSEG_9;
      4'hA:    seg = SSEG_A;
      4'hB:    seg = SSEG_B;
      4'hC:    seg = SSEG_C;
      4'hD:    seg = SSEG_D;
      4'hE:    seg = SSEG_E;
      default: seg = SSEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// Inverse segment table: 7-bit active-low pattern to {nibble, legal, blank}.
// Purely combinational, zero latency; no flow control.
module sseg_to_hex
  import sseg_pkg::*;
(
  input  logic [6:0] sseg_i,
  output logic [3:0] nibble_o,
  output logic       legal_o,
  output logic       blank_o
);

  always_comb begin
    nibble_o = 4'h0;
    legal_o  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (sseg_i == hex_to_sseg(4'(i))) begin
        nibble_o = 4'(i);
        legal_o  = 1'b1;
      end
    end
    blank_o = (sseg_i == SSEG_BLANK);
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Rebuilds the displayed N-digit hex value from scanned anode/segment lines; capture lands STABLE_CYCLES+2 edges after a dwell starts.
// Pure observer, no backpressure; SSEG_SCAN_TIMEOUT_EN adds the stale-scan timeout.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_DIGITS-1:0]     an,
  input  logic [6:0]              sseg,
  output logic [4*N_DIGITS-1:0]   value,
  output logic [N_DIGITS-1:0]     digit_valid,
  output logic                    frame_done,
  output logic                    frame_ok,
  output logic                    pat_err,
  output logic                    stale
);

  localparam int PW = N_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [N_DIGITS-1:0] DIG_ONE = N_DIGITS'(1);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sseg_scan_decoder: parameter out of range");
  end

  logic [PW-1:0]         pair_q, prev_q;
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  capture;
  logic [4*N_DIGITS-1:0] value_q, value_d;
  logic [N_DIGITS-1:0]   valid_q, valid_d;
  logic [N_DIGITS-1:0]   seen_q, seen_d, seen_nxt;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_ok_q, frame_ok_d;
  logic                  pat_err_q, pat_err_d;
  logic                  tmo_hit;

  logic [N_DIGITS-1:0] sel;
  logic [6:0]          seg_q;
  logic                dwell_legal, same;
  logic [3:0]          hex_nib;
  logic                hex_legal, hex_blank;

  assign sel         = ~pair_q[PW-1:7];
  assign seg_q       = pair_q[6:0];
  assign dwell_legal = (sel != '0) && ((sel & (sel - DIG_ONE)) == '0);
  assign same        = (pair_q == prev_q);

  sseg_to_hex u_dec (
    .sseg_i   (seg_q),
    .nibble_o (hex_nib),
    .legal_o  (hex_legal),
    .blank_o  (hex_blank)
  );

  // Any change of {an, sseg}, including a segment-only change, restarts settling; this rejects ghosting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dwell_legal) state_d = SETTLE;
      end
      SETTLE: begin
        if (!same) begin
          cnt_d   = '0;
          state_d = dwell_legal ? SETTLE : IDLE;
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          cnt_d   = '0;
          capture = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!same) state_d = dwell_legal ? SETTLE : IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    value_d      = value_q;
    valid_d      = valid_q;
    seen_d       = seen_q;
    seen_nxt     = seen_q | sel;
    frame_done_d = 1'b0;
    frame_ok_d   = 1'b0;
    pat_err_d    = 1'b0;
    if (capture) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (sel[i]) begin
          if (hex_legal) value_d[4*i +: 4] = hex_nib;
          valid_d[i] = hex_legal;
        end
      end
      pat_err_d = !hex_legal && !hex_blank;
      if (&seen_nxt) begin
        frame_done_d = 1'b1;
        frame_ok_d   = &valid_d;
        seen_d       = '0;
      end else begin
        seen_d = seen_nxt;
      end
    end else if (tmo_hit) begin
      valid_d = '0;
      seen_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_q       <= '1;
      prev_q       <= '1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      value_q      <= '0;
      valid_q      <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      pat_err_q    <= 1'b0;
    end else begin
      pair_q       <= {an, sseg};
      prev_q       <= pair_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      pat_err_q    <= pat_err_d;
    end
  end

`ifdef SSEG_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          stale_q;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Counter saturates at the limit so the timeout fires once per idle period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      if (capture) begin
        tmo_q   <= '0;
        stale_q <= 1'b0;
      end else begin
        if (tmo_q != TW'(TIMEOUT_CYCLES)) tmo_q <= tmo_q + 1'b1;
        if (tmo_hit) stale_q <= 1'b1;
      end
    end
  end

  assign stale = stale_q;
`else
  assign tmo_hit = 1'b0;
  assign stale   = 1'b0;
`endif

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign frame_ok    = frame_ok_q;
  assign pat_err     = pat_err_q;

endmodule
